// File: rtl/sram_like_pkg.sv
// rtl/sram_like_pkg.sv - shared constants and types for the sram-like arbiter
package sram_like_pkg;
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sram_like_arbiter_if.sv
// rtl/sram_like_arbiter_if.sv - upstream master lanes and downstream slave channel of the arbiter
interface sram_like_arbiter_if #(
   parameter int NUM_M  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [NUM_M-1:0]        m_req;
   logic [NUM_M-1:0]        m_wr;
   logic [2*NUM_M-1:0]      m_size;
   logic [ADDR_W*NUM_M-1:0] m_addr;
   logic [DATA_W*NUM_M-1:0] m_wdata;
   logic [NUM_M-1:0]        m_addr_ok;
   logic [NUM_M-1:0]        m_data_ok;
   logic [DATA_W-1:0]       m_rdata;

   logic                    s_req;
   logic                    s_wr;
   logic [1:0]              s_size;
   logic [ADDR_W-1:0]       s_addr;
   logic [DATA_W-1:0]       s_wdata;
   logic                    s_addr_ok;
   logic                    s_data_ok;
   logic [DATA_W-1:0]       s_rdata;

   // master: the environment (requesters plus memory); slave: the arbiter itself
   modport master (
      output m_req, m_wr, m_size, m_addr, m_wdata, s_addr_ok, s_data_ok, s_rdata,
      input  m_addr_ok, m_data_ok, m_rdata, s_req, s_wr, s_size, s_addr, s_wdata
   );
   modport slave (
      input  m_req, m_wr, m_size, m_addr, m_wdata, s_addr_ok, s_data_ok, s_rdata,
      output m_addr_ok, m_data_ok, m_rdata, s_req, s_wr, s_size, s_addr, s_wdata
   );
endinterface

// File: rtl/id_fifo.sv
// rtl/id_fifo.sv - in-order FIFO of granted master IDs awaiting their responses
module id_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 1
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   i_push,
   input  logic [W-1:0]           i_din,
   input  logic                   i_pop,
   output logic [W-1:0]           o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == (PW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end

   // DEPTH is a power of two, so pointers wrap naturally
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - N-to-1 sram-like bus arbiter with grant lock and in-order response routing
module sram_like_arbiter
   import sram_like_pkg::*;
#(
   parameter int NUM_M    = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int OUTST    = 4,
   parameter int ARB_MODE = 0
) (
   input  logic                   clk,
   input  logic                   resetn,
   sram_like_arbiter_if.slave     bus,
   output logic [$clog2(OUTST):0] outst_cnt,
   output logic                   err
);
   localparam int IDW = clog2_min1(NUM_M);
   localparam int CW  = $clog2(OUTST) + 1;

   lock_state_t    r_state;
   lock_state_t    w_state_nxt;
   logic [IDW-1:0] r_lock_id;
   logic [IDW-1:0] w_lock_id_nxt;
   logic [IDW-1:0] r_rr_ptr;
   logic [IDW-1:0] w_sel;
   logic [IDW-1:0] w_grant;
   logic [IDW-1:0] w_head;
   logic [CW-1:0]  w_count;
   logic           r_err;
   logic           w_full;
   logic           w_empty;
   logic           w_hs;
   logic           w_pop;
   int             w_sum;

   // lowest k wins in round-robin because later loop iterations overwrite
   always_comb begin
      w_sel = '0;
      w_sum = 0;
      if (ARB_MODE == ARB_FIXED) begin
         for (int i = 0; i < NUM_M; i++)
            if (bus.m_req[i]) w_sel = IDW'(i);
      end else begin
         for (int k = NUM_M - 1; k >= 0; k--) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= NUM_M) w_sum = w_sum - NUM_M;
            if (bus.m_req[w_sum[IDW-1:0]]) w_sel = w_sum[IDW-1:0];
         end
      end
   end

   assign w_grant     = (r_state == ST_LOCKED) ? r_lock_id : w_sel;
   assign bus.s_req   = resetn & (|bus.m_req) & ~w_full;
   assign w_hs        = bus.s_req & bus.s_addr_ok;
   assign w_pop       = resetn & bus.s_data_ok & ~w_empty;
   assign bus.s_wr    = bus.m_wr[w_grant];
   assign bus.s_size  = bus.m_size[2*int'(w_grant) +: 2];
   assign bus.s_addr  = bus.m_addr[ADDR_W*int'(w_grant) +: ADDR_W];
   assign bus.s_wdata = bus.m_wdata[DATA_W*int'(w_grant) +: DATA_W];
   assign bus.m_rdata = bus.s_rdata;
   assign outst_cnt   = w_count;
   assign err         = r_err;

   always_comb begin
      bus.m_addr_ok = '0;
      bus.m_data_ok = '0;
      if (w_hs)  bus.m_addr_ok[w_grant] = 1'b1;
      if (w_pop) bus.m_data_ok[w_head]  = 1'b1;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_lock_id_nxt = r_lock_id;
      case (r_state)
         ST_OPEN: begin
            if (bus.s_req && !bus.s_addr_ok) begin
               w_state_nxt   = ST_LOCKED;
               w_lock_id_nxt = w_sel;
            end
         end
         ST_LOCKED: begin
            if (w_hs) w_state_nxt = ST_OPEN;
         end
         default: w_state_nxt = ST_OPEN;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_OPEN;
         r_lock_id <= '0;
         r_rr_ptr  <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_lock_id <= w_lock_id_nxt;
         if (w_hs && ARB_MODE == ARB_RR)
            r_rr_ptr <= (int'(w_grant) == NUM_M - 1) ? '0 : w_grant + 1'b1;
         if (bus.s_data_ok && w_empty) r_err <= 1'b1;
      end
   end

   id_fifo #(.DEPTH(OUTST), .W(IDW)) u_id_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_hs),
      .i_din   (w_grant),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - scoreboard bench for sram_like_arbiter in fixed and round-robin modes
module tb_sram_like_arbiter;
   import sram_like_pkg::*;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int OS = 4;
   localparam logic [31:0] A0 = 32'h0000_1000;
   localparam logic [31:0] A1 = 32'h0000_2000;
   localparam logic [31:0] W0 = 32'hAAAA_0000;
   localparam logic [31:0] W1 = 32'hBBBB_1111;

   typedef struct {
      logic [1:0]  mask;
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;

   logic clk;
   logic resetn;
   logic [2:0] cnt0;
   logic [2:0] cnt1;
   logic err0;
   logic err1;
   int checks = 0;
   int failures = 0;
   exp_t qa0[$];
   exp_t qa1[$];
   exp_t qd0[$];
   exp_t qd1[$];
   exp_t e0;
   exp_t e1;

   sram_like_arbiter_if #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW)) bus0();
   sram_like_arbiter_if #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW)) bus1();

   sram_like_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .OUTST(OS), .ARB_MODE(ARB_FIXED)) dut0 (
      .clk(clk), .resetn(resetn), .bus(bus0), .outst_cnt(cnt0), .err(err0));
   sram_like_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .OUTST(OS), .ARB_MODE(ARB_RR)) dut1 (
      .clk(clk), .resetn(resetn), .bus(bus1), .outst_cnt(cnt1), .err(err1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_a(input int d, input int m);
      exp_t e;
      e.mask = (m == 0) ? 2'b01 : 2'b10;
      e.a    = (m == 0) ? A0 : A1;
      e.d    = (m == 0) ? W0 : W1;
      if (d == 0) qa0.push_back(e);
      else        qa1.push_back(e);
   endtask

   task automatic exp_d(input int d, input int m, input logic [31:0] rd);
      exp_t e;
      e.mask = (m == 0) ? 2'b01 : 2'b10;
      e.a    = '0;
      e.d    = rd;
      if (d == 0) qd0.push_back(e);
      else        qd1.push_back(e);
   endtask

   // monitors: pop the scoreboard whenever either DUT presents a handshake
   always @(negedge clk) begin
      if (resetn) begin
         if (bus0.m_addr_ok != 2'b00) begin
            if (qa0.size() == 0) chk("dut0_unexpected_addr_ok", bus0.m_addr_ok, 0);
            else begin
               e0 = qa0.pop_front();
               chk("dut0_addr_ok", bus0.m_addr_ok, e0.mask);
               chk("dut0_s_addr", bus0.s_addr, e0.a);
               chk("dut0_s_wdata", bus0.s_wdata, e0.d);
            end
         end
         if (bus0.m_data_ok != 2'b00) begin
            if (qd0.size() == 0) chk("dut0_unexpected_data_ok", bus0.m_data_ok, 0);
            else begin
               e0 = qd0.pop_front();
               chk("dut0_data_ok", bus0.m_data_ok, e0.mask);
               chk("dut0_m_rdata", bus0.m_rdata, e0.d);
            end
         end
         if (bus1.m_addr_ok != 2'b00) begin
            if (qa1.size() == 0) chk("dut1_unexpected_addr_ok", bus1.m_addr_ok, 0);
            else begin
               e1 = qa1.pop_front();
               chk("dut1_addr_ok", bus1.m_addr_ok, e1.mask);
               chk("dut1_s_addr", bus1.s_addr, e1.a);
            end
         end
         if (bus1.m_data_ok != 2'b00) begin
            if (qd1.size() == 0) chk("dut1_unexpected_data_ok", bus1.m_data_ok, 0);
            else begin
               e1 = qd1.pop_front();
               chk("dut1_data_ok", bus1.m_data_ok, e1.mask);
               chk("dut1_m_rdata", bus1.m_rdata, e1.d);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      bus0.m_req = 2'b11; bus0.m_wr = 2'b10; bus0.m_size = {SIZE_WORD, SIZE_BYTE};
      bus0.m_addr = {A1, A0}; bus0.m_wdata = {W1, W0};
      bus0.s_addr_ok = 1'b1; bus0.s_data_ok = 1'b1; bus0.s_rdata = '0;
      bus1.m_req = 2'b11; bus1.m_wr = 2'b10; bus1.m_size = {SIZE_WORD, SIZE_HALF};
      bus1.m_addr = {A1, A0}; bus1.m_wdata = {W1, W0};
      bus1.s_addr_ok = 1'b1; bus1.s_data_ok = 1'b0; bus1.s_rdata = '0;
      #12;
      chk("rst_s_req", bus0.s_req, 0);
      chk("rst_addr_ok", bus0.m_addr_ok, 0);
      chk("rst_data_ok", bus0.m_data_ok, 0);
      chk("rst_cnt", cnt0, 0);
      chk("rst_err", err0, 0);
      chk("rst_s_req_rr", bus1.s_req, 0);
      bus0.m_req = 2'b00; bus0.s_addr_ok = 1'b0; bus0.s_data_ok = 1'b0;
      bus1.m_req = 2'b00; bus1.s_addr_ok = 1'b0;
      step();
      resetn = 1'b1;
      step();

      // round-robin: both requesting, grants alternate and pointer wraps
      bus1.m_req = 2'b11; bus1.s_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin exp_a(1, i % 2); step(); end
      chk("rr_full_cnt", cnt1, 4);
      chk("rr_full_s_req", bus1.s_req, 0);
      step();
      bus1.m_req = 2'b00; bus1.s_addr_ok = 1'b0; bus1.s_data_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus1.s_rdata = 32'h100 + i; exp_d(1, i % 2, 32'h100 + i); step();
      end
      bus1.s_data_ok = 1'b0;
      chk("rr_drain_cnt", cnt1, 0);
      chk("rr_err", err1, 0);

      // fixed priority: both requesting, master 1 wins every cycle
      bus0.m_req = 2'b11; bus0.s_addr_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin exp_a(0, 1); step(); end
      bus0.m_req = 2'b00; bus0.s_addr_ok = 1'b0;
      chk("fp_cnt3", cnt0, 3);
      bus0.s_data_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus0.s_rdata = 32'hD000 + i; exp_d(0, 1, 32'hD000 + i); step();
      end
      bus0.s_data_ok = 1'b0;
      chk("fp_drain_cnt", cnt0, 0);

      // grant lock: master 0 stalled, master 1 arrives in cycle 2
      bus0.m_req = 2'b01; bus0.s_addr_ok = 1'b0; step();
      bus0.m_req = 2'b11;
      chk("lock_c2_addr", bus0.s_addr, A0);
      chk("lock_c2_req", bus0.s_req, 1);
      step();
      chk("lock_c3_addr", bus0.s_addr, A0);
      chk("lock_c3_size", bus0.s_size, SIZE_BYTE);
      step();
      bus0.s_addr_ok = 1'b1; exp_a(0, 0);
      chk("lock_c4_wr", bus0.s_wr, 0);
      step();
      exp_a(0, 1);
      chk("unlock_wr", bus0.s_wr, 1);
      step();
      bus0.m_req = 2'b00; bus0.s_addr_ok = 1'b0; bus0.s_data_ok = 1'b1;
      bus0.s_rdata = 32'hE0; exp_d(0, 0, 32'hE0); step();
      bus0.s_rdata = 32'hE1; exp_d(0, 1, 32'hE1); step();
      bus0.s_data_ok = 1'b0;

      // fill to OUTST, pop at full (no bypass), push+pop at OUTST-1
      bus0.s_addr_ok = 1'b1;
      bus0.m_req = 2'b01; exp_a(0, 0); step();
      bus0.m_req = 2'b10; exp_a(0, 1); step();
      bus0.m_req = 2'b01; exp_a(0, 0); step();
      bus0.m_req = 2'b10; exp_a(0, 1); step();
      bus0.m_req = 2'b11;
      chk("full_cnt", cnt0, 4);
      chk("full_s_req", bus0.s_req, 0);
      step();
      bus0.s_data_ok = 1'b1; bus0.s_rdata = 32'hF0; exp_d(0, 0, 32'hF0);
      chk("full_pop_no_bypass", bus0.s_req, 0);
      step();
      chk("after_pop_s_req", bus0.s_req, 1);
      chk("after_pop_cnt", cnt0, 3);
      bus0.s_rdata = 32'hF1; exp_d(0, 1, 32'hF1); exp_a(0, 1); step();
      chk("pushpop_cnt", cnt0, 3);
      bus0.m_req = 2'b00; bus0.s_addr_ok = 1'b0;
      bus0.s_rdata = 32'hF2; exp_d(0, 0, 32'hF2); step();
      bus0.s_rdata = 32'hF3; exp_d(0, 1, 32'hF3); step();
      bus0.s_rdata = 32'hF4; exp_d(0, 1, 32'hF4); step();
      bus0.s_data_ok = 1'b0;
      chk("full_drain_cnt", cnt0, 0);
      chk("pre_err", err0, 0);

      // response with nothing outstanding
      bus0.s_data_ok = 1'b1; step();
      bus0.s_data_ok = 1'b0;
      chk("empty_resp_err", err0, 1);
      chk("empty_resp_cnt", cnt0, 0);
      step(); step();
      chk("err_sticky", err0, 1);

      // reset with three outstanding
      bus0.m_req = 2'b01; bus0.s_addr_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin exp_a(0, 0); step(); end
      bus0.s_addr_ok = 1'b0;
      chk("pre_rst_cnt", cnt0, 3);
      resetn = 1'b0;
      #1;
      chk("mid_rst_cnt", cnt0, 0);
      chk("mid_rst_err", err0, 0);
      chk("mid_rst_s_req", bus0.s_req, 0);
      step();
      resetn = 1'b1;
      bus0.m_req = 2'b00;
      step();
      bus0.s_data_ok = 1'b1; step();
      bus0.s_data_ok = 1'b0;
      chk("post_rst_err", err0, 1);
      chk("post_rst_cnt", cnt0, 0);

      step(); step();
      chk("sb_qa0_empty", qa0.size(), 0);
      chk("sb_qd0_empty", qd0.size(), 0);
      chk("sb_qa1_empty", qa1.size(), 0);
      chk("sb_qd1_empty", qd1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
